// File: rtl/aes_decrypt_control.sv
// Sequencing FSM for the AES inverse cipher: steps the decrypt datapath through
// InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns and counts the round-key index down.
module aes_decrypt_control #(
    parameter int unsigned NR = 10,
    parameter int unsigned CW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          decrypt,
    input  logic          key_ready,
    output logic          init,
    output logic          is_first_ark,
    output logic          en_round_out,
    output logic          en_reg_row_out,
    output logic          en_reg_sub_out,
    output logic          en_reg_col_out,
    output logic          en_Dout,
    output logic [CW-1:0] round_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARK0 = 3'd1,
        ISR  = 3'd2,
        ISB  = 3'd3,
        ARK  = 3'd4,
        IMC  = 3'd5,
        OUT  = 3'd6,
        DONE = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] idx_d;
    logic          start;

    assign start = decrypt && key_ready;

    // State and round-key index registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            round_idx <= CW'(NR);
        end else begin
            state_q   <= state_d;
            round_idx <= idx_d;
        end
    end

    // Next-state and strobe decode; round_idx holds at 0 after the final ARK
    always_comb begin
        state_d        = state_q;
        idx_d          = round_idx;
        init           = 1'b0;
        is_first_ark   = 1'b0;
        en_round_out   = 1'b0;
        en_reg_row_out = 1'b0;
        en_reg_sub_out = 1'b0;
        en_reg_col_out = 1'b0;
        en_Dout        = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    init    = 1'b1;
                    idx_d   = CW'(NR);
                    state_d = ARK0;
                end
            end
            ARK0: begin
                busy         = 1'b1;
                is_first_ark = 1'b1;
                en_round_out = 1'b1;
                idx_d        = round_idx - CW'(1);
                state_d      = ISR;
            end
            ISR: begin
                busy           = 1'b1;
                en_reg_row_out = 1'b1;
                state_d        = ISB;
            end
            ISB: begin
                busy           = 1'b1;
                en_reg_sub_out = 1'b1;
                state_d        = ARK;
            end
            ARK: begin
                busy         = 1'b1;
                en_round_out = 1'b1;
                if (round_idx != '0) begin
                    idx_d   = round_idx - CW'(1);
                    state_d = IMC;
                end else begin
                    state_d = OUT;
                end
            end
            IMC: begin
                busy           = 1'b1;
                en_reg_col_out = 1'b1;
                state_d        = ISR;
            end
            OUT: begin
                busy    = 1'b1;
                en_Dout = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    init    = 1'b1;
                    idx_d   = CW'(NR);
                    state_d = ARK0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_decrypt_control.sv
// Directed bench for aes_decrypt_control (NR=10): latency, round-key order,
// key_ready gating, back-to-back operation and mid-operation reset.
module tb_aes_decrypt_control;

    logic       clock = 1'b0;
    logic       reset;
    logic       decrypt;
    logic       key_ready;
    logic       init, is_first_ark, en_round_out, en_reg_row_out;
    logic       en_reg_sub_out, en_reg_col_out, en_Dout, busy, done;
    logic [3:0] round_idx;

    int errors = 0;
    int checks = 0;

    aes_decrypt_control #(.NR(10), .CW(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .decrypt        (decrypt),
        .key_ready      (key_ready),
        .init           (init),
        .is_first_ark   (is_first_ark),
        .en_round_out   (en_round_out),
        .en_reg_row_out (en_reg_row_out),
        .en_reg_sub_out (en_reg_sub_out),
        .en_reg_col_out (en_reg_col_out),
        .en_Dout        (en_Dout),
        .round_idx      (round_idx),
        .busy           (busy),
        .done           (done)
    );

    always #5 clock = ~clock;

    // Cycle log filled on the falling edge; expectations for busy/done come
    // from the number of cycles since the last accepted start.
    int cyc = 0;
    int init_t, init_cnt, ark_cnt, col_cnt, col_late, dout_cnt, done_cnt;
    int onehot_err, busy_err, done_err, first_err;
    int dout_ts [0:3];
    logic [3:0] ark_idx [0:15];
    logic seen_idx0, op_active;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        int d, n;
        if (reset) begin
            op_active = 1'b0;
        end else begin
            d = cyc - init_t;
            if (busy !== (op_active && d >= 1 && d <= 41)) busy_err++;
            if (done !== (op_active && d >= 42)) done_err++;
            if (is_first_ark !== (op_active && d == 1)) first_err++;
            n = int'(en_round_out) + int'(en_reg_row_out) + int'(en_reg_sub_out)
              + int'(en_reg_col_out) + int'(en_Dout);
            if (n > 1) onehot_err++;
            if (init) begin
                init_t = cyc;
                init_cnt++;
                op_active = 1'b1;
            end
            if (en_round_out) begin
                if (ark_cnt < 16) ark_idx[ark_cnt] = round_idx;
                ark_cnt++;
                if (round_idx == 4'd0) seen_idx0 = 1'b1;
            end
            if (en_reg_col_out) begin
                col_cnt++;
                if (seen_idx0) col_late++;
            end
            if (en_Dout) begin
                if (dout_cnt < 4) dout_ts[dout_cnt] = cyc;
                dout_cnt++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic clear_log();
        init_t = 0; init_cnt = 0; ark_cnt = 0; col_cnt = 0; col_late = 0;
        dout_cnt = 0; done_cnt = 0; onehot_err = 0; busy_err = 0;
        done_err = 0; first_err = 0; seen_idx0 = 1'b0; op_active = 1'b0;
    endtask

    // Advance to just after a rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        decrypt = 1'b0;
        key_ready = 1'b0;
        reset = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b0;
        clear_log();
        next_cycle();
    endtask

    task automatic wait_dout(input int target, input int budget);
        for (int i = 0; i < budget && dout_cnt < target; i++) @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        decrypt = 1'b0;
        key_ready = 1'b1;
        reset = 1'b1;
        #12;
        checks++;
        if (round_idx !== 4'd10) begin
            errors++; $display("FAIL reset_round_idx: got %0d want 10", round_idx);
        end
        checks++;
        if ({init, is_first_ark, en_round_out, en_reg_row_out, en_reg_sub_out,
             en_reg_col_out, en_Dout, busy, done} !== 9'b0) begin
            errors++; $display("FAIL reset_outputs: got %b want 000000000",
                {init, is_first_ark, en_round_out, en_reg_row_out, en_reg_sub_out,
                 en_reg_col_out, en_Dout, busy, done});
        end
        next_cycle();
        reset = 1'b0;
        clear_log();
        next_cycle();
    endtask

    task automatic test_single_op();
        decrypt = 1'b1;
        key_ready = 1'b1;
        #1;
        checks++;
        if (init !== 1'b1) begin
            errors++; $display("FAIL t1_init_accept: got %b want 1", init);
        end
        next_cycle();
        decrypt = 1'b0;
        wait_dout(1, 60);
        checks++;
        if (dout_cnt != 1) begin
            errors++; $display("FAIL t1_dout_timeout: got %0d pulses want 1", dout_cnt);
        end
        checks++;
        if (dout_ts[0] - init_t != 41) begin
            errors++; $display("FAIL t1_dout_latency: got %0d want 41", dout_ts[0] - init_t);
        end
        repeat (5) next_cycle();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL t1_done_held: got done=%b busy=%b want 1/0", done, busy);
        end
    endtask

    task automatic test_round_order();
        checks++;
        if (ark_cnt != 11) begin
            errors++; $display("FAIL t2_ark_count: got %0d want 11", ark_cnt);
        end
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (ark_idx[k] !== 4'(10 - k)) begin
                errors++; $display("FAIL t2_ark_idx[%0d]: got %0d want %0d", k, ark_idx[k], 10 - k);
            end
        end
        checks++;
        if (col_cnt != 9 || col_late != 0) begin
            errors++; $display("FAIL t2_imc: got %0d pulses (%0d late) want 9 (0)", col_cnt, col_late);
        end
        checks++;
        if (onehot_err != 0 || busy_err != 0 || done_err != 0 || first_err != 0) begin
            errors++; $display("FAIL t6_single: onehot=%0d busy=%0d done=%0d first=%0d want 0",
                onehot_err, busy_err, done_err, first_err);
        end
    endtask

    task automatic test_key_gate();
        apply_reset();
        decrypt = 1'b1;
        key_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (init !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL t3_gated[%0d]: got init=%b busy=%b want 0/0", i, init, busy);
            end
            next_cycle();
        end
        key_ready = 1'b1;
        #1;
        checks++;
        if (init !== 1'b1) begin
            errors++; $display("FAIL t3_init_on_key: got %b want 1", init);
        end
        next_cycle();
        decrypt = 1'b0;
        key_ready = 1'b0;
        wait_dout(1, 60);
        checks++;
        if (dout_cnt != 1 || dout_ts[0] - init_t != 41) begin
            errors++; $display("FAIL t3_complete: got %0d pulses latency %0d want 1/41",
                dout_cnt, dout_ts[0] - init_t);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        decrypt = 1'b1;
        key_ready = 1'b1;
        wait_dout(2, 120);
        decrypt = 1'b0;
        checks++;
        if (dout_cnt != 2) begin
            errors++; $display("FAIL t4_timeout: got %0d pulses want 2", dout_cnt);
        end
        checks++;
        if (dout_ts[1] - dout_ts[0] != 42) begin
            errors++; $display("FAIL t4_spacing: got %0d want 42", dout_ts[1] - dout_ts[0]);
        end
        checks++;
        if (done_cnt != 1 || init_cnt != 2) begin
            errors++; $display("FAIL t4_done_once: got done=%0d inits=%0d want 1/2", done_cnt, init_cnt);
        end
        repeat (3) next_cycle();
        checks++;
        if (init_cnt != 2 || done !== 1'b1) begin
            errors++; $display("FAIL t4_stop: got inits=%0d done=%b want 2/1", init_cnt, done);
        end
        checks++;
        if (onehot_err != 0 || busy_err != 0 || done_err != 0 || first_err != 0 || col_cnt != 18) begin
            errors++; $display("FAIL t6_b2b: onehot=%0d busy=%0d done=%0d first=%0d col=%0d want 0/0/0/0/18",
                onehot_err, busy_err, done_err, first_err, col_cnt);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        decrypt = 1'b1;
        key_ready = 1'b1;
        next_cycle();
        decrypt = 1'b0;
        repeat (19) next_cycle();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || round_idx !== 4'd10 || en_Dout !== 1'b0) begin
            errors++; $display("FAIL t5_async: got busy=%b done=%b idx=%0d dout=%b want 0/0/10/0",
                busy, done, round_idx, en_Dout);
        end
        next_cycle();
        reset = 1'b0;
        repeat (30) next_cycle();
        checks++;
        if (dout_cnt != 0 || done !== 1'b0) begin
            errors++; $display("FAIL t5_aborted: got dout=%0d done=%b want 0/0", dout_cnt, done);
        end
        decrypt = 1'b1;
        next_cycle();
        decrypt = 1'b0;
        wait_dout(1, 60);
        checks++;
        if (dout_cnt != 1 || dout_ts[0] - init_t != 41 || done !== 1'b1) begin
            errors++; $display("FAIL t5_fresh: got pulses=%0d latency=%0d done=%b want 1/41/1",
                dout_cnt, dout_ts[0] - init_t, done);
        end
    endtask

    initial begin
        reset = 1'b1;
        decrypt = 1'b0;
        key_ready = 1'b0;
        clear_log();
        test_reset();
        test_single_op();
        test_round_order();
        test_key_gate();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
